// File: rtl/fir_transposed_sat.sv
// Transposed-form FIR with rounded Q-format tap products, saturating accumulation,
// sticky saturation flag and a shadow coefficient bank committed between samples.
module fir_transposed_sat #(
  parameter int DATA_WIDTH = 24,
  parameter int FRAC_BITS  = 23,
  parameter int NUM_TAPS   = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clear,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] iv_din,
  input  logic                  i_coef_wr,
  input  logic [ADDR_WIDTH-1:0] iv_coef_addr,
  input  logic [DATA_WIDTH-1:0] iv_coef_data,
  input  logic                  i_coef_commit,
  output logic                  o_coef_pending,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] ov_dout,
  output logic                  o_sat
);

  localparam int W  = DATA_WIDTH;
  localparam int PW = 2 * W + 1;

  localparam logic signed [PW-1:0] RND_C  = {{(PW-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);
  localparam logic signed [PW-1:0] PMAX_C = {{(W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PW-1:0] PMIN_C = {{(W+2){1'b1}}, {(W-1){1'b0}}};
  localparam logic [W-1:0]         MAX_C  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]         MIN_C  = {1'b1, {(W-1){1'b0}}};

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} coef_state_e;

  // Returns {saturated, value} of the rounded, rescaled product x*h.
  function automatic logic [W:0] mul_rnd_sat(input logic [W-1:0] x, input logic [W-1:0] h);
    logic signed [PW-1:0] xe, he, acc, sh;
    logic [W:0]           res;
    xe  = {{(W+1){x[W-1]}}, x};
    he  = {{(W+1){h[W-1]}}, h};
    acc = xe * he + RND_C;
    sh  = acc >>> FRAC_BITS;
    if (sh > PMAX_C) begin
      res = {1'b1, MAX_C};
    end else if (sh < PMIN_C) begin
      res = {1'b1, MIN_C};
    end else begin
      res = {1'b0, sh[W-1:0]};
    end
    return res;
  endfunction

  // Returns {saturated, value} of a + b clamped to the signed W-bit range.
  function automatic logic [W:0] add_sat(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] sum, res;
    sum = {a[W-1], a} + {b[W-1], b};
    if (sum[W] != sum[W-1]) begin
      res = sum[W] ? {1'b1, MIN_C} : {1'b1, MAX_C};
    end else begin
      res = {1'b0, sum[W-1:0]};
    end
    return res;
  endfunction

  logic [W-1:0]        shd_q   [NUM_TAPS];
  logic [W-1:0]        shd_d   [NUM_TAPS];
  logic [W-1:0]        act_q   [NUM_TAPS];
  logic [W-1:0]        act_d   [NUM_TAPS];
  logic [W-1:0]        s_q     [1:NUM_TAPS-1];
  logic [W-1:0]        s_d     [1:NUM_TAPS-1];
  logic [W-1:0]        prod_s  [NUM_TAPS];
  logic [NUM_TAPS-1:0] prod_sat_s;
  logic [NUM_TAPS-1:0] sum_sat_s;
  logic [W-1:0]        dout_d, dout_q;
  logic                sat_hit_s, sat_q, valid_q, commit_s;
  coef_state_e         state_q, state_d;

  // Tap products and the candidate partial sums for a sample arriving this cycle.
  always_comb begin
    prod_sat_s = '0;
    sum_sat_s  = '0;
    dout_d     = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      {prod_sat_s[k], prod_s[k]} = mul_rnd_sat(iv_din, act_q[k]);
    end
    s_d[NUM_TAPS-1] = prod_s[NUM_TAPS-1];
    for (int k = 1; k < NUM_TAPS - 1; k++) begin
      {sum_sat_s[k], s_d[k]} = add_sat(prod_s[k], s_q[k+1]);
    end
    {sum_sat_s[0], dout_d} = add_sat(prod_s[0], s_q[1]);
    sat_hit_s = (|prod_sat_s) | (|sum_sat_s);
  end

  // Shadow writes and the commit FSM; the active bank only moves on idle cycles.
  always_comb begin
    state_d  = state_q;
    commit_s = 1'b0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      if (i_coef_wr && (iv_coef_addr == ADDR_WIDTH'(k))) begin
        shd_d[k] = iv_coef_data;
      end else begin
        shd_d[k] = shd_q[k];
      end
    end
    case (state_q)
      IDLE: begin
        if (i_coef_commit && !i_valid) begin
          commit_s = 1'b1;
        end else if (i_coef_commit) begin
          state_d = PENDING;
        end else begin
          state_d = IDLE;
        end
      end
      PENDING: begin
        if (!i_valid) begin
          commit_s = 1'b1;
          state_d  = IDLE;
        end else begin
          state_d = PENDING;
        end
      end
      default: state_d = IDLE;
    endcase
    for (int k = 0; k < NUM_TAPS; k++) begin
      act_d[k] = commit_s ? shd_d[k] : act_q[k];
    end
  end

  // State registers: coefficient banks, FSM, tap sums and output stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      for (int k = 0; k < NUM_TAPS; k++) begin
        shd_q[k] <= '0;
        act_q[k] <= '0;
      end
      for (int k = 1; k < NUM_TAPS; k++) begin
        s_q[k] <= '0;
      end
      dout_q  <= '0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int k = 0; k < NUM_TAPS; k++) begin
        shd_q[k] <= shd_d[k];
        act_q[k] <= act_d[k];
      end
      if (i_clear) begin
        for (int k = 1; k < NUM_TAPS; k++) begin
          s_q[k] <= '0;
        end
        dout_q  <= '0;
        valid_q <= 1'b0;
        sat_q   <= 1'b0;
      end else if (i_valid) begin
        for (int k = 1; k < NUM_TAPS; k++) begin
          s_q[k] <= s_d[k];
        end
        dout_q  <= dout_d;
        valid_q <= 1'b1;
        sat_q   <= sat_q | sat_hit_s;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign o_coef_pending = (state_q == PENDING);
  assign o_valid        = valid_q;
  assign ov_dout        = dout_q;
  assign o_sat          = sat_q;

endmodule

// File: tb/tb_fir_transposed_sat.sv
// Bench for fir_transposed_sat: directed scenarios plus random traffic checked
// against a sample-history reference model of the filter equations.
module tb_fir_transposed_sat;
  localparam int W = 24;
  localparam int F = 23;
  localparam int N = 4;
  localparam int A = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0, valid = 1'b0, coef_wr = 1'b0, coef_commit = 1'b0;
  logic [W-1:0] din = '0, coef_data = '0;
  logic [A-1:0] coef_addr = '0;
  logic         coef_pending, out_valid, sat;
  logic [W-1:0] dout;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int           hx [N];
  int           hb [N][N];
  int           m_act [N];
  int           m_shd [N];
  logic [W-1:0] m_dout;
  bit           m_valid, m_sat, m_pend;

  fir_transposed_sat #(.DATA_WIDTH(W), .FRAC_BITS(F), .NUM_TAPS(N), .ADDR_WIDTH(A)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_valid(valid), .iv_din(din),
    .i_coef_wr(coef_wr), .iv_coef_addr(coef_addr), .iv_coef_data(coef_data),
    .i_coef_commit(coef_commit), .o_coef_pending(coef_pending), .o_valid(out_valid),
    .ov_dout(dout), .o_sat(sat)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int sx(input int v);
    return (v <<< 8) >>> 8;
  endfunction

  function automatic int prod_m(input int x, input int h, output bit f);
    longint p;
    p = (longint'(x) * longint'(h) + (longint'(1) <<< (F - 1))) >>> F;
    f = 1'b0;
    if (p > 64'sd8388607) begin p = 64'sd8388607; f = 1'b1; end
    else if (p < -64'sd8388608) begin p = -64'sd8388608; f = 1'b1; end
    return int'(p);
  endfunction

  function automatic int add_m(input int a, input int b, output bit f);
    longint s;
    s = longint'(a) + longint'(b);
    f = 1'b0;
    if (s > 64'sd8388607) begin s = 64'sd8388607; f = 1'b1; end
    else if (s < -64'sd8388608) begin s = -64'sd8388608; f = 1'b1; end
    return int'(s);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      hx[i] = 0; m_act[i] = 0; m_shd[i] = 0;
      for (int j = 0; j < N; j++) hb[i][j] = 0;
    end
    m_dout = '0; m_valid = 1'b0; m_sat = 1'b0; m_pend = 1'b0;
  endtask

  // y[n] = sat(p(x[n],h0) + sat(p(x[n-1],h1) + ...)), each past sample with its own bank.
  task automatic model_edge(input bit v, input int x, input bit clr, input bit wr,
                            input int addr, input int data, input bit cm);
    bit f, flag;
    int acc, pj, y;
    if (clr) begin
      for (int i = 0; i < N; i++) hx[i] = 0;
      m_dout = '0; m_valid = 1'b0; m_sat = 1'b0;
    end else if (v) begin
      for (int i = N - 1; i > 0; i--) begin hx[i] = hx[i-1]; hb[i] = hb[i-1]; end
      hx[0] = sx(x);
      hb[0] = m_act;
      flag = 1'b0; y = 0;
      for (int k = 0; k < N; k++) begin
        acc = prod_m(hx[N-1-k], hb[N-1-k][N-1], f); flag |= f;
        for (int j = N - 2 - k; j >= 0; j--) begin
          pj = prod_m(hx[j], hb[j][k+j], f); flag |= f;
          acc = add_m(pj, acc, f); flag |= f;
        end
        if (k == 0) y = acc;
      end
      m_dout = y[W-1:0]; m_valid = 1'b1; m_sat |= flag;
    end else begin
      m_valid = 1'b0;
    end
    if (wr && addr < N) m_shd[addr] = sx(data);
    if (m_pend) begin
      if (!v) begin m_act = m_shd; m_pend = 1'b0; end
    end else if (cm) begin
      if (!v) m_act = m_shd;
      else m_pend = 1'b1;
    end
  endtask

  task automatic cycle(input bit v, input int x, input bit clr, input bit wr,
                       input int addr, input int data, input bit cm);
    valid = v; din = x[W-1:0]; clear = clr; coef_wr = wr;
    coef_addr = addr[A-1:0]; coef_data = data[W-1:0]; coef_commit = cm;
    @(posedge clk);
    model_edge(v, x, clr, wr, addr, data, cm);
    #1;
  endtask

  task automatic load_coefs(input int h0, input int h1, input int h2, input int h3);
    cycle(1'b0, 0, 1'b0, 1'b1, 0, h0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1, 1, h1, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1, 2, h2, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1, 3, h3, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #12;
    n_checks++;
    if ({out_valid, sat, coef_pending, dout} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h want %h", {out_valid, sat, coef_pending, dout}, 27'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    cycle(1'b0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
    n_checks++;
    if ({out_valid, dout} !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_idle_hold: got %h want %h", {out_valid, dout}, 25'd0);
    end
  endtask

  task automatic test_impulse();
    int exp_y [5] = '{32'h200000, 32'h100000, 32'h080000, 32'h040000, 32'h0};
    load_coefs(32'h400000, 32'h200000, 32'h100000, 32'h080000);
    cycle(1'b0, 0, 1'b1, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, (i == 0) ? 32'h400000 : 0, 1'b0, 1'b0, 0, 0, 1'b0);
      n_checks++;
      if ({out_valid, sat, dout} !== {1'b1, 1'b0, exp_y[i][W-1:0]}) begin
        n_fail++;
        $display("FAIL impulse[%0d]: got v=%b sat=%b y=%h want v=1 sat=0 y=%h",
                 i, out_valid, sat, dout, exp_y[i][W-1:0]);
      end
      n_checks++;
      if ({out_valid, sat, coef_pending, dout} !== {m_valid, m_sat, m_pend, m_dout}) begin
        n_fail++;
        $display("FAIL impulse_model[%0d]: got %h want %h", i,
                 {out_valid, sat, coef_pending, dout}, {m_valid, m_sat, m_pend, m_dout});
      end
    end
  endtask

  task automatic test_saturation();
    load_coefs(32'h7FFFFF, 32'h7FFFFF, 32'h7FFFFF, 32'h7FFFFF);
    cycle(1'b0, 0, 1'b1, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, (i < 4) ? 32'h7FFFFF : 0, 1'b0, 1'b0, 0, 0, 1'b0);
      if (i >= 1 && i < 4) begin
        n_checks++;
        if ({dout, sat} !== {24'h7FFFFF, 1'b1}) begin
          n_fail++;
          $display("FAIL sat_clamp[%0d]: got y=%h sat=%b want y=7fffff sat=1", i, dout, sat);
        end
      end
      n_checks++;
      if ({out_valid, sat, dout} !== {m_valid, m_sat, m_dout}) begin
        n_fail++;
        $display("FAIL sat_model[%0d]: got %h want %h", i,
                 {out_valid, sat, dout}, {m_valid, m_sat, m_dout});
      end
    end
    n_checks++;
    if (sat !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_sticky: got %b want 1", sat);
    end
    // Clear with a live sample: the sample must be dropped.
    cycle(1'b1, 32'h7FFFFF, 1'b1, 1'b0, 0, 0, 1'b0);
    n_checks++;
    if ({out_valid, sat, dout} !== 26'd0) begin
      n_fail++;
      $display("FAIL sat_clear: got %h want %h", {out_valid, sat, dout}, 26'd0);
    end
  endtask

  task automatic test_corner();
    load_coefs(32'h800000, 0, 0, 0);
    cycle(1'b0, 0, 1'b1, 1'b0, 0, 0, 1'b0);
    cycle(1'b1, 32'h800000, 1'b0, 1'b0, 0, 0, 1'b0);
    n_checks++;
    if ({dout, sat} !== {24'h7FFFFF, 1'b1}) begin
      n_fail++;
      $display("FAIL corner_neg_neg: got y=%h sat=%b want y=7fffff sat=1", dout, sat);
    end
    load_coefs(32'h400000, 0, 0, 0);
    cycle(1'b0, 0, 1'b1, 1'b0, 0, 0, 1'b0);
    cycle(1'b1, 32'h000001, 1'b0, 1'b0, 0, 0, 1'b0);
    n_checks++;
    if ({dout, sat} !== {24'h000001, 1'b0}) begin
      n_fail++;
      $display("FAIL corner_round_up: got y=%h sat=%b want y=000001 sat=0", dout, sat);
    end
    cycle(1'b1, 32'hFFFFFF, 1'b0, 1'b0, 0, 0, 1'b0);
    n_checks++;
    if ({dout, sat} !== {24'h000000, 1'b0}) begin
      n_fail++;
      $display("FAIL corner_round_neg: got y=%h sat=%b want y=000000 sat=0", dout, sat);
    end
  endtask

  task automatic test_commit_load();
    load_coefs(32'h400000, 32'h200000, 32'h100000, 32'h080000);
    cycle(1'b0, 0, 1'b1, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 14; i++) begin
      bit v;
      v = (i != 9);
      cycle(v, int'($urandom_range(0, 32'hFFFFFF)), 1'b0, (i >= 1 && i <= 4), i - 1,
            int'($urandom_range(0, 32'hFFFFFF)), (i == 5 || i == 7));
      if (i >= 5 && i <= 8) begin
        n_checks++;
        if (coef_pending !== 1'b1) begin
          n_fail++;
          $display("FAIL commit_pending[%0d]: got %b want 1", i, coef_pending);
        end
      end
      if (i >= 9) begin
        n_checks++;
        if (coef_pending !== 1'b0) begin
          n_fail++;
          $display("FAIL commit_applied[%0d]: got %b want 0", i, coef_pending);
        end
      end
      n_checks++;
      if ({out_valid, sat, coef_pending, dout} !== {m_valid, m_sat, m_pend, m_dout}) begin
        n_fail++;
        $display("FAIL commit_model[%0d]: got %h want %h", i,
                 {out_valid, sat, coef_pending, dout}, {m_valid, m_sat, m_pend, m_dout});
      end
    end
  endtask

  task automatic test_addr_collision();
    int exp_y [4] = '{32'h080000, 32'h100000, 32'h080000, 32'h040000};
    load_coefs(32'h400000, 32'h200000, 32'h100000, 32'h080000);
    cycle(1'b0, 0, 1'b0, 1'b1, 5, 32'h7FFFFF, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1, 0, 32'h100000, 1'b1);
    cycle(1'b0, 0, 1'b1, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, (i == 0) ? 32'h400000 : 0, 1'b0, 1'b0, 0, 0, 1'b0);
      n_checks++;
      if ({out_valid, dout} !== {1'b1, exp_y[i][W-1:0]}) begin
        n_fail++;
        $display("FAIL addr_collision[%0d]: got v=%b y=%h want v=1 y=%h",
                 i, out_valid, dout, exp_y[i][W-1:0]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      bit clr, v;
      clr = ($urandom_range(0, 19) == 0);
      v   = !clr && ($urandom_range(0, 9) < 8);
      cycle(v, int'($urandom_range(0, 32'hFFFFFF)), clr, ($urandom_range(0, 5) == 0),
            int'($urandom_range(0, 5)), int'($urandom_range(0, 32'hFFFFFF)),
            ($urandom_range(0, 11) == 0));
      n_checks++;
      if ({out_valid, sat, coef_pending, dout} !== {m_valid, m_sat, m_pend, m_dout}) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h want %h", i,
                 {out_valid, sat, coef_pending, dout}, {m_valid, m_sat, m_pend, m_dout});
      end
    end
  endtask

  task automatic test_reset_pending();
    load_coefs(32'h7FFFFF, 32'h7FFFFF, 32'h7FFFFF, 32'h7FFFFF);
    cycle(1'b1, 32'h7FFFFF, 1'b0, 1'b0, 0, 0, 1'b0);
    cycle(1'b1, 32'h7FFFFF, 1'b0, 1'b0, 0, 0, 1'b1);
    cycle(1'b1, 32'h7FFFFF, 1'b0, 1'b0, 0, 0, 1'b0);
    n_checks++;
    if ({coef_pending, sat, out_valid} !== 3'b111) begin
      n_fail++;
      $display("FAIL pre_reset_state: got %b want 111", {coef_pending, sat, out_valid});
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({out_valid, sat, coef_pending, dout} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_midstream: got %h want %h", {out_valid, sat, coef_pending, dout}, 27'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, (i == 0) ? 32'h400000 : 0, 1'b0, 1'b0, 0, 0, 1'b0);
      n_checks++;
      if ({out_valid, sat, coef_pending, dout} !== {1'b1, 1'b0, 1'b0, 24'h0}) begin
        n_fail++;
        $display("FAIL reset_coefs_cleared[%0d]: got v=%b sat=%b pend=%b y=%h want 1 0 0 000000",
                 i, out_valid, sat, coef_pending, dout);
      end
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_saturation();
    test_corner();
    test_commit_load();
    test_addr_collision();
    test_random();
    test_reset_pending();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
